// File: rtl/mips_cpu_load_unit.sv
// Load unit for the Harvard MIPS data side.
// A request accepted in IDLE issues one word-aligned Avalon read. The read is
// held through waitrequest stalls and aborted after a bounded number of stall
// cycles. The returned word is then extracted, extended or merged (LWL/LWR)
// into a 32-bit writeback value. Every output comes straight from a flop.
module mips_cpu_load_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           rt_old,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           result,
  output logic                  fault,
  output logic [ADDR_WIDTH-1:0] avm_address,
  output logic                  avm_read,
  output logic [3:0]            avm_byteenable,
  input  logic [31:0]           avm_readdata,
  input  logic                  avm_waitrequest
);

  // The counter is at least 8 bits and wide enough to reach TIMEOUT_CYCLES.
  localparam int unsigned CNT_W_MIN = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W     = (CNT_W_MIN > 8) ? CNT_W_MIN : 8;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic             TO_EN     = (TIMEOUT_CYCLES != 32'd0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LBU = 3'b001;
  localparam logic [2:0] OP_LH  = 3'b010;
  localparam logic [2:0] OP_LHU = 3'b011;
  localparam logic [2:0] OP_LW  = 3'b101;
  localparam logic [2:0] OP_LWL = 3'b110;
  localparam logic [2:0] OP_LWR = 3'b111;

  // A request faults without a bus cycle on the reserved op or a misaligned halfword/word.
  function automatic logic req_fault_f(input logic [2:0] f_op, input logic [1:0] f_k);
    logic flt;
    case (f_op)
      OP_LH, OP_LHU: flt = f_k[0];
      OP_LW:         flt = (f_k != 2'b00);
      OP_LB, OP_LBU,
      OP_LWL, OP_LWR: flt = 1'b0;
      default:       flt = 1'b1;
    endcase
    return flt;
  endfunction

  // Byte lanes touched by the load.
  function automatic logic [3:0] byteenable_f(input logic [2:0] f_op, input logic [1:0] f_k);
    logic [3:0] be;
    case (f_op)
      OP_LB, OP_LBU: be = 4'b0001 << f_k;
      OP_LH, OP_LHU: be = f_k[1] ? 4'b1100 : 4'b0011;
      OP_LW:         be = 4'b1111;
      OP_LWL:        be = (4'b0010 << f_k) - 4'b0001;
      OP_LWR:        be = 4'b1111 << f_k;
      default:       be = 4'b0000;
    endcase
    return be;
  endfunction

  // Writeback value from the returned word, the byte offset and the old rt.
  function automatic logic [31:0] result_f(input logic [2:0]  f_op,
                                           input logic [1:0]  f_k,
                                           input logic [31:0] f_m,
                                           input logic [31:0] f_rt);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res;
    case (f_k)
      2'd0:    byte_v = f_m[7:0];
      2'd1:    byte_v = f_m[15:8];
      2'd2:    byte_v = f_m[23:16];
      2'd3:    byte_v = f_m[31:24];
      default: byte_v = 8'h00;
    endcase
    half_v = f_k[1] ? f_m[31:16] : f_m[15:0];
    case (f_op)
      OP_LB:  res = {{24{byte_v[7]}}, byte_v};
      OP_LBU: res = {24'h000000, byte_v};
      OP_LH:  res = {{16{half_v[15]}}, half_v};
      OP_LHU: res = {16'h0000, half_v};
      OP_LW:  res = f_m;
      OP_LWL: begin
        case (f_k)
          2'd0:    res = {f_m[7:0],  f_rt[23:0]};
          2'd1:    res = {f_m[15:0], f_rt[15:0]};
          2'd2:    res = {f_m[23:0], f_rt[7:0]};
          2'd3:    res = f_m;
          default: res = 32'h0000_0000;
        endcase
      end
      OP_LWR: begin
        case (f_k)
          2'd0:    res = f_m;
          2'd1:    res = {f_rt[31:24], f_m[31:8]};
          2'd2:    res = {f_rt[31:16], f_m[31:16]};
          2'd3:    res = {f_rt[31:8],  f_m[31:24]};
          default: res = 32'h0000_0000;
        endcase
      end
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  logic [1:0]            state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [1:0]            k_q, k_d;
  logic [31:0]           rt_q, rt_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      cnt_inc_s;
  logic [31:0]           result_q, result_d;
  logic                  fault_q, fault_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  avm_read_q, avm_read_d;
  logic [ADDR_WIDTH-1:0] avm_address_q, avm_address_d;
  logic [3:0]            avm_byteenable_q, avm_byteenable_d;

  assign cnt_inc_s = cnt_q + CNT_ONE;

  // Next-state, operand latching and result computation; strobes follow the next state.
  always_comb begin
    state_d          = state_q;
    op_d             = op_q;
    k_d              = k_q;
    rt_d             = rt_q;
    cnt_d            = cnt_q;
    result_d         = result_q;
    fault_d          = fault_q;
    avm_address_d    = avm_address_q;
    avm_byteenable_d = avm_byteenable_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d = op;
          k_d  = addr[1:0];
          rt_d = rt_old;
          if (req_fault_f(op, addr[1:0])) begin
            state_d  = S_DONE;
            fault_d  = 1'b1;
            result_d = 32'h0000_0000;
          end else begin
            state_d          = S_READ;
            cnt_d            = '0;
            avm_address_d    = {addr[ADDR_WIDTH-1:2], 2'b00};
            avm_byteenable_d = byteenable_f(op, addr[1:0]);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (!avm_waitrequest) begin
          state_d  = S_DONE;
          fault_d  = 1'b0;
          result_d = result_f(op_q, k_q, avm_readdata, rt_q);
        end else begin
          cnt_d = cnt_inc_s;
          if (TO_EN && (cnt_inc_s == TIMEOUT_C)) begin
            state_d  = S_DONE;
            fault_d  = 1'b1;
            result_d = 32'h0000_0000;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    avm_read_d = (state_d == S_READ);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      op_q             <= 3'b000;
      k_q              <= 2'b00;
      rt_q             <= 32'h0000_0000;
      cnt_q            <= '0;
      result_q         <= 32'h0000_0000;
      fault_q          <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      avm_read_q       <= 1'b0;
      avm_address_q    <= '0;
      avm_byteenable_q <= 4'b0000;
    end else begin
      state_q          <= state_d;
      op_q             <= op_d;
      k_q              <= k_d;
      rt_q             <= rt_d;
      cnt_q            <= cnt_d;
      result_q         <= result_d;
      fault_q          <= fault_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      avm_read_q       <= avm_read_d;
      avm_address_q    <= avm_address_d;
      avm_byteenable_q <= avm_byteenable_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign result         = result_q;
  assign fault          = fault_q;
  assign avm_read       = avm_read_q;
  assign avm_address    = avm_address_q;
  assign avm_byteenable = avm_byteenable_q;

endmodule

// File: doc/mips_cpu_load_unit.md
# mips_cpu_load_unit

Sequential load unit for the Harvard MIPS core's data side. It accepts a load request from the execute stage and issues one word-aligned read on the Avalon data bus, holding it through any waitrequest stall. It then extracts, sign/zero-extends or merges (LWL/LWR) the returned data into a 32-bit writeback value. It adds misalignment and bus-timeout fault detection, which a purely combinational selector cannot provide.

## Interface
- TIMEOUT_CYCLES, 255: maximum consecutive waitrequest-high cycles before the read is aborted; 0 disables the timeout.
- ADDR_WIDTH, 32: byte-address width of `addr` and `avm_address`.

- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
- start  in  1  request strobe, sampled only in IDLE
- op  in  3  000 LB, 001 LBU, 010 LH, 011 LHU, 101 LW, 110 LWL, 111 LWR; 100 reserved
- addr  in  ADDR_WIDTH  byte address of the load
- rt_old  in  32  current rt value, used for the LWL/LWR merge
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse; result/fault valid this cycle
- result  out  32  writeback value
- fault  out  1  qualifies done: misaligned, reserved op, or timeout
- avm_address  out  ADDR_WIDTH  {addr[ADDR_WIDTH-1:2], 2'b00}
- avm_read  out  1  read strobe
- avm_byteenable  out  4  active byte lanes
- avm_readdata  in  32  read data, little-endian lanes: byte k = bits [8k+7:8k]
- avm_waitrequest  in  1  slave stall

## Operation
- States: IDLE, READ, DONE.
- IDLE, start=1: latch op, addr, rt_old. Then branch on the request:
  - Fault case (op=100; LH/LHU with addr[0]=1; LW with addr[1:0]!=0): go to DONE with fault=1, result=0, no bus cycle.
  - Otherwise: go to READ.
- start is ignored outside IDLE. Latched operands are immune to input changes after the start cycle.
- READ:
  - avm_read=1; address and byteenable are held constant.
  - waitrequest=0: capture readdata, compute result, go to DONE.
  - waitrequest=1: increment the wait counter. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES, drop avm_read and go to DONE with fault=1, result=0.
- DONE: done=1 for exactly one cycle, then IDLE. start is not accepted in DONE.
- Byteenable, with k=addr[1:0]:
  - LB/LBU: 1<<k
  - LH/LHU: 0011 (k=0) or 1100 (k=2)
  - LW: 1111
  - LWL: (2<<k)-1
  - LWR: 1111<<k
- Result, with m = readdata:
  - LB: sign-extend byte k; LBU: zero-extend byte k.
  - LH/LHU: sign- or zero-extend halfword k[1].
  - LW: m.
  - LWL: (m << 8(3-k)) with the low 8(3-k) bits taken from rt_old.
  - LWR: (m >> 8k) with the high 8k bits taken from rt_old.
- result and fault hold their values after done until the next done.
- Wait counter is 8 bits wide minimum (wide enough for TIMEOUT_CYCLES) and clears on entry to READ.

## Timing
- Reset (reset=0 at an edge): state IDLE; busy, done, fault, avm_read = 0; result, avm_address = 0; avm_byteenable = 0000; counter = 0. This takes effect from any state, including mid-READ, where avm_read drops on the next edge.
- Zero-wait load: start seen at edge 0 → avm_read high in cycle 1 → done in cycle 2. Latency is 2 cycles plus N, the number of waitrequest-high cycles.
- Fault without a bus cycle: done 1 cycle after start.
- Timeout: done occurs TIMEOUT_CYCLES+1 cycles after READ entry. avm_read is never asserted in DONE.
- Back-to-back: the earliest next start is accepted in the cycle after DONE, i.e. one request per 3 cycles at zero wait.

## Test plan
- LB: addr=0x1003, readdata=0x80FF_1234, zero wait → byteenable=1000, avm_address=0x1000, result=0xFFFF_FF80, done 2 cycles after start, fault=0. The same stimulus with LBU gives result=0x0000_0080.
- LH: addr=0x2002, readdata=0x9ABC_0000, waitrequest high 3 cycles → avm_read held 4 cycles, result=0xFFFF_9ABC, done 5 cycles after start.
- LWL/LWR with rt_old=0x1122_3344 and readdata=0xAABB_CCDD:
  - LWL addr k=1 → byteenable=0011, result=0xCCDD_3344.
  - LWR addr k=2 → byteenable=1100, result=0x1122_AABB.
- LW at addr=0x3001 → no avm_read, done 1 cycle after start, fault=1, result=0. Op=100 behaves the same.
- TIMEOUT_CYCLES=4 with waitrequest stuck high → avm_read high exactly 4 cycles, then done with fault=1. A start pulsed during READ is ignored.
- reset=0 asserted mid-READ with waitrequest high → next cycle avm_read=0 and busy=0. No done pulse, and a subsequent LW completes normally.
